// File: rtl/io_pkg.sv
// io_pkg: shared constants and state encoding for the I/O handshake controller.
package io_pkg;
    localparam int IO_DATA_WIDTH = 32;
    localparam int IO_SW_WIDTH   = 16;
    localparam logic [1:0] MEMTOREG_IO = 2'b11;
    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_WAIT_PRESS   = 3'd1;
    localparam logic [2:0] ST_WAIT_RELEASE = 3'd2;
    localparam logic [2:0] ST_DONE         = 3'd3;
    localparam logic [2:0] ST_HALTED       = 3'd4;
    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        WAIT_PRESS   = ST_WAIT_PRESS,
        WAIT_RELEASE = ST_WAIT_RELEASE,
        DONE         = ST_DONE,
        HALTED       = ST_HALTED
    } state_t;
endpackage

// File: rtl/button_debouncer.sv
// button_debouncer: synchronizes and debounces a raw pushbutton, emitting single-cycle press/release edges.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o,
    output logic release_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic sync1_q, sync2_q, prev_q, level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    // prev_q is the stable reference: the count only grows while the synchronized level holds still
    always_comb begin
        cnt_d   = (sync2_q != prev_q) ? '0 : (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
        level_d = (cnt_q == LAST) ? prev_q : level_q;
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end
    assign press_o   = level_d & ~level_q;
    assign release_o = ~level_d & level_q;
endmodule

// File: rtl/io_handshake_controller.sv
// io_handshake_controller: services input/output/halt instructions against switches, display and a confirm button.
module io_handshake_controller
    import io_pkg::*;
#(
    parameter int DATA_WIDTH      = IO_DATA_WIDTH,
    parameter int SW_WIDTH        = IO_SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int OUTPUT_WAIT     = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  inputInst,
    input  logic                  outputInst,
    input  logic                  halt,
    input  logic [DATA_WIDTH-1:0] out_data,
    input  logic [SW_WIDTH-1:0]   switches,
    input  logic                  confirm_btn,
    output logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] display,
    output logic                  io_stall,
    output logic                  io_commit,
    output logic                  waiting,
    output logic                  halted
);
    state_t state_q, state_d;
    logic is_in_q, is_in_d, halted_q, press, rel;
    logic [DATA_WIDTH-1:0] in_data_q, in_data_d, display_q, display_d;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
        .clk_i    (clock),
        .rst_i    (reset),
        .btn_i    (confirm_btn),
        .press_o  (press),
        .release_o(rel)
    );

    always_comb begin
        state_d   = state_q;
        is_in_d   = is_in_q;
        in_data_d = in_data_q;
        display_d = display_q;
        io_stall  = 1'b0;
        io_commit = 1'b0;
        case (state_q)
            IDLE: begin
                if (inputInst) begin
                    io_stall = 1'b1;
                    is_in_d  = 1'b1;
                    state_d  = WAIT_PRESS;
                end else if (outputInst) begin
                    io_stall  = 1'b1;
                    is_in_d   = 1'b0;
                    display_d = out_data;
                    state_d   = (OUTPUT_WAIT != 0) ? WAIT_PRESS : DONE;
                end else if (halt) begin
                    io_stall = 1'b1;
                    state_d  = HALTED;
                end
            end
            WAIT_PRESS: begin
                io_stall = 1'b1;
                if (press) begin
                    in_data_d = is_in_q ? DATA_WIDTH'(switches) : in_data_q;
                    state_d   = WAIT_RELEASE;
                end
            end
            WAIT_RELEASE: begin
                io_stall = 1'b1;
                state_d  = rel ? DONE : WAIT_RELEASE;
            end
            DONE: begin
                io_commit = 1'b1;
                state_d   = IDLE;
            end
            HALTED: io_stall = 1'b1;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            is_in_q   <= 1'b0;
            in_data_q <= '0;
            display_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            is_in_q   <= is_in_d;
            in_data_q <= in_data_d;
            display_q <= display_d;
            halted_q  <= (state_q == HALTED);
        end
    end

    assign in_data = in_data_q;
    assign display = display_q;
    assign waiting = (state_q == WAIT_PRESS);
    assign halted  = halted_q;
endmodule

// File: tb/tb_io_handshake_controller.sv
// tb_io_handshake_controller: directed checks of the I/O handshake with a short debounce window.
module tb_io_handshake_controller;
    logic clock = 1'b0, reset = 1'b0;
    logic inputInst = 1'b0, outputInst = 1'b0, halt = 1'b0, confirm_btn = 1'b0;
    logic [31:0] out_data = '0;
    logic [15:0] switches = '0;
    logic [31:0] in_data, display, in_data0, display0;
    logic io_stall, io_commit, waiting, halted;
    logic io_stall0, io_commit0, waiting0, halted0;
    int vec = 0, errs = 0;

    always #5 clock = ~clock;

    io_handshake_controller #(.DEBOUNCE_CYCLES(4), .OUTPUT_WAIT(1)) dut (
        .clock(clock), .reset(reset), .inputInst(inputInst), .outputInst(outputInst), .halt(halt),
        .out_data(out_data), .switches(switches), .confirm_btn(confirm_btn),
        .in_data(in_data), .display(display), .io_stall(io_stall), .io_commit(io_commit),
        .waiting(waiting), .halted(halted)
    );

    io_handshake_controller #(.DEBOUNCE_CYCLES(4), .OUTPUT_WAIT(0)) dut0 (
        .clock(clock), .reset(reset), .inputInst(inputInst), .outputInst(outputInst), .halt(halt),
        .out_data(out_data), .switches(switches), .confirm_btn(confirm_btn),
        .in_data(in_data0), .display(display0), .io_stall(io_stall0), .io_commit(io_commit0),
        .waiting(waiting0), .halted(halted0)
    );

    task automatic do_reset();
        inputInst = 0; outputInst = 0; halt = 0; confirm_btn = 0;
        @(negedge clock); reset = 1;
        @(negedge clock); @(negedge clock); reset = 0;
    endtask

    task automatic hold_btn(input logic v, input int n);
        confirm_btn = v;
        repeat (n) @(negedge clock);
    endtask

    task automatic test_reset();
        do_reset();
        vec++; if ({in_data, display} !== 64'h0) begin errs++; $display("FAIL reset_data got %h/%h want 0/0", in_data, display); end
        vec++; if ({io_stall, io_commit, waiting, halted} !== 4'b0) begin errs++; $display("FAIL reset_ctrl got %b want 0000", {io_stall, io_commit, waiting, halted}); end
        vec++; if ({io_stall0, io_commit0, waiting0, halted0, display0} !== 36'h0) begin errs++; $display("FAIL reset_ctrl0 got %b/%h want 0", {io_stall0, io_commit0, waiting0, halted0}, display0); end
    endtask

    task automatic test_input();
        int c, bad;
        do_reset();
        switches = 16'hA5C3; inputInst = 1; halt = 1;
        #1;
        vec++; if (io_stall !== 1'b1) begin errs++; $display("FAIL input_stall_idle got %b want 1", io_stall); end
        @(negedge clock); inputInst = 0; halt = 0;
        vec++; if (waiting !== 1'b1) begin errs++; $display("FAIL input_waiting got %b want 1", waiting); end
        bad = 0;
        confirm_btn = 1;
        for (int i = 0; i < 10; i++) begin @(negedge clock); if (io_stall !== 1'b1 || io_commit !== 1'b0) bad++; end
        vec++; if (bad != 0) begin errs++; $display("FAIL input_stall_press got %0d bad cycles want 0", bad); end
        vec++; if (in_data !== 32'h0000A5C3 || waiting !== 1'b0) begin errs++; $display("FAIL input_capture got %h w=%b want 0000a5c3 w=0", in_data, waiting); end
        confirm_btn = 0; c = 0;
        for (int i = 0; i < 20 && c == 0; i++) begin
            @(negedge clock);
            if (io_commit) begin c++; if (io_stall !== 1'b0) bad++; end
        end
        vec++; if (c != 1 || bad != 0) begin errs++; $display("FAIL input_commit got %0d commits %0d stalled want 1/0", c, bad); end
        @(negedge clock);
        vec++; if (io_commit !== 1'b0 || io_stall !== 1'b0 || in_data !== 32'h0000A5C3) begin errs++; $display("FAIL input_after got c=%b s=%b %h want 0 0 0000a5c3", io_commit, io_stall, in_data); end
    endtask

    task automatic test_bounce();
        int k, bad, c;
        do_reset();
        switches = 16'h0F0F; inputInst = 1;
        @(negedge clock); inputInst = 0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            confirm_btn = ((i / 2) % 2 == 0);
            @(negedge clock);
            if (waiting !== 1'b1) bad++;
        end
        vec++; if (bad != 0) begin errs++; $display("FAIL bounce_press_rejected got %0d early accepts want 0", bad); end
        confirm_btn = 1; k = 0;
        for (int i = 0; i < 20 && waiting === 1'b1; i++) begin @(negedge clock); k++; end
        vec++; if (k < 6 || k > 10) begin errs++; $display("FAIL bounce_press_delay got %0d cycles want 6..10", k); end
        bad = 0; c = 0;
        for (int i = 0; i < 8; i++) begin @(negedge clock); if (io_stall !== 1'b1 || waiting !== 1'b0) bad++; if (io_commit) c++; end
        for (int i = 0; i < 8; i++) begin
            confirm_btn = ((i / 2) % 2 == 1);
            @(negedge clock);
            if (io_stall !== 1'b1) bad++;
            if (io_commit) c++;
        end
        vec++; if (bad != 0 || c != 0) begin errs++; $display("FAIL bounce_hold_release got %0d bad %0d commits want 0/0", bad, c); end
        confirm_btn = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clock); if (io_commit) c++; end
        vec++; if (c != 1 || in_data !== 32'h00000F0F) begin errs++; $display("FAIL bounce_commit got %0d commits %h want 1 00000f0f", c, in_data); end
    endtask

    task automatic test_output();
        int c, bad;
        do_reset();
        out_data = 32'hDEADBEEF; outputInst = 1; halt = 1;
        #1;
        vec++; if (io_stall0 !== 1'b1 || io_commit0 !== 1'b0) begin errs++; $display("FAIL out0_stall got s=%b c=%b want 1 0", io_stall0, io_commit0); end
        @(negedge clock); outputInst = 0; halt = 0;
        vec++; if (display0 !== 32'hDEADBEEF || io_commit0 !== 1'b1 || io_stall0 !== 1'b0) begin errs++; $display("FAIL out0_done got %h c=%b s=%b want deadbeef 1 0", display0, io_commit0, io_stall0); end
        @(negedge clock);
        vec++; if (io_commit0 !== 1'b0 || io_stall0 !== 1'b0) begin errs++; $display("FAIL out0_after got c=%b s=%b want 0 0", io_commit0, io_stall0); end
        vec++; if (display !== 32'hDEADBEEF || waiting !== 1'b1) begin errs++; $display("FAIL out1_wait got %h w=%b want deadbeef 1", display, waiting); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin @(negedge clock); if (waiting !== 1'b1 || io_commit !== 1'b0) bad++; end
        vec++; if (bad != 0) begin errs++; $display("FAIL out1_hold got %0d bad cycles want 0", bad); end
        hold_btn(1, 10);
        vec++; if (waiting !== 1'b0 || io_stall !== 1'b1 || in_data !== 32'h0) begin errs++; $display("FAIL out1_pressed got w=%b s=%b %h want 0 1 0", waiting, io_stall, in_data); end
        confirm_btn = 0; c = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clock); if (io_commit) c++; end
        vec++; if (c != 1 || in_data !== 32'h0 || display !== 32'hDEADBEEF) begin errs++; $display("FAIL out1_commit got %0d %h %h want 1 0 deadbeef", c, in_data, display); end
    endtask

    task automatic test_back_to_back();
        int c, bad;
        do_reset();
        switches = 16'h1234; inputInst = 1;
        @(negedge clock); inputInst = 0;
        hold_btn(1, 10);
        c = 0; confirm_btn = 0;
        for (int i = 0; i < 20 && c == 0; i++) begin @(negedge clock); if (io_commit) c++; end
        vec++; if (c != 1 || in_data !== 32'h1234) begin errs++; $display("FAIL b2b_first got %0d %h want 1 00001234", c, in_data); end
        hold_btn(1, 10);
        switches = 16'h5678; inputInst = 1;
        @(negedge clock); inputInst = 0;
        bad = 0; c = 0;
        for (int i = 0; i < 15; i++) begin @(negedge clock); if (waiting !== 1'b1) bad++; if (io_commit) c++; end
        confirm_btn = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clock); if (waiting !== 1'b1) bad++; if (io_commit) c++; end
        vec++; if (bad != 0 || c != 0 || in_data !== 32'h1234) begin errs++; $display("FAIL b2b_stale_press got %0d bad %0d commits %h want 0 0 00001234", bad, c, in_data); end
        hold_btn(1, 10);
        confirm_btn = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clock); if (io_commit) c++; end
        vec++; if (c != 1 || in_data !== 32'h5678) begin errs++; $display("FAIL b2b_second got %0d %h want 1 00005678", c, in_data); end
    endtask

    task automatic test_halt();
        int bad;
        do_reset();
        halt = 1;
        #1;
        vec++; if (io_stall !== 1'b1 || halted !== 1'b0) begin errs++; $display("FAIL halt_now got s=%b h=%b want 1 0", io_stall, halted); end
        @(negedge clock); halt = 0;
        @(negedge clock);
        vec++; if (halted !== 1'b1 || io_stall !== 1'b1) begin errs++; $display("FAIL halt_reg got h=%b s=%b want 1 1", halted, io_stall); end
        bad = 0;
        out_data = 32'h12345678; outputInst = 1; inputInst = 1;
        for (int i = 0; i < 4; i++) begin @(negedge clock); if (io_stall !== 1'b1 || halted !== 1'b1) bad++; end
        outputInst = 0; inputInst = 0;
        confirm_btn = 1;
        for (int i = 0; i < 10; i++) begin @(negedge clock); if (io_commit || waiting || io_stall !== 1'b1) bad++; end
        confirm_btn = 0;
        for (int i = 0; i < 10; i++) begin @(negedge clock); if (io_commit || io_stall !== 1'b1) bad++; end
        vec++; if (bad != 0 || display !== 32'h0) begin errs++; $display("FAIL halt_sticky got %0d bad %h want 0 0", bad, display); end
        do_reset();
        vec++; if (halted !== 1'b0 || io_stall !== 1'b0) begin errs++; $display("FAIL halt_reset got h=%b s=%b want 0 0", halted, io_stall); end
    endtask

    task automatic test_reset_midwait();
        int c;
        do_reset();
        out_data = 32'hCAFEF00D; outputInst = 1;
        @(negedge clock); outputInst = 0;
        hold_btn(1, 10);
        confirm_btn = 0;
        for (int i = 0; i < 20; i++) @(negedge clock);
        switches = 16'hA5C3; inputInst = 1;
        @(negedge clock); inputInst = 0;
        hold_btn(1, 10);
        vec++; if (waiting !== 1'b0 || io_stall !== 1'b1 || in_data !== 32'hA5C3) begin errs++; $display("FAIL midwait_state got w=%b s=%b %h want 0 1 0000a5c3", waiting, io_stall, in_data); end
        #2 reset = 1;
        #1;
        vec++; if ({in_data, display} !== 64'h0 || {io_stall, io_commit, waiting, halted} !== 4'b0) begin errs++; $display("FAIL midwait_async got %h/%h %b want 0/0 0000", in_data, display, {io_stall, io_commit, waiting, halted}); end
        confirm_btn = 0;
        @(negedge clock); @(negedge clock); reset = 0;
        switches = 16'h00FF; inputInst = 1;
        @(negedge clock); inputInst = 0;
        vec++; if (waiting !== 1'b1) begin errs++; $display("FAIL midwait_fresh got w=%b want 1", waiting); end
        hold_btn(1, 10);
        confirm_btn = 0; c = 0;
        for (int i = 0; i < 20; i++) begin @(negedge clock); if (io_commit) c++; end
        vec++; if (c != 1 || in_data !== 32'h00FF) begin errs++; $display("FAIL midwait_commit got %0d %h want 1 000000ff", c, in_data); end
    endtask

    initial begin
        test_reset();
        test_input();
        test_bounce();
        test_output();
        test_back_to_back();
        test_halt();
        test_reset_midwait();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
